// File: rtl/zmod_pkg.sv
// Shared PRBS-7 definitions for the ZMOD loopback link (checker and transmitter).
package zmod_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  localparam int PRBS_ORDER = 7;

  // x^7 + x^6 + 1: the next bit is the XOR of the two oldest bits in the window.
  function automatic logic prbs7_next(input logic [PRBS_ORDER-1:0] state);
    return state[6] ^ state[5];
  endfunction

endpackage

// File: rtl/zmod_prbs_lane_check.sv
// One lane of the PRBS-7 checker: acquires lock on the incoming stream,
// then free-runs its own LFSR and counts mismatching bits.
module zmod_prbs_lane_check
  import zmod_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_ERR = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             d_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             locked_d_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_pulse_o
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int CERR_W = $clog2(UNLOCK_ERR + 1);
  localparam int FILL_W = $clog2(PRBS_ORDER + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRBS_ORDER);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [CERR_W-1:0] CERR_LAST = CERR_W'(UNLOCK_ERR - 1);

  prbs_state_t               state_q, state_d;
  logic [PRBS_ORDER-1:0]     lfsr_q, lfsr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [RUN_W-1:0]          run_q, run_d;
  logic [CERR_W-1:0]         cerr_q, cerr_d;
  logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;
  logic                      err_pulse_q, err_pulse_d;
  logic                      pred_s;
  logic                      mismatch_s;
  logic                      cnt_inc_s;

  assign pred_s     = prbs7_next(lfsr_q);
  assign mismatch_s = d_i ^ pred_s;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    run_d       = run_q;
    cerr_d      = cerr_q;
    cnt_inc_s   = 1'b0;
    err_pulse_d = 1'b0;
    if (en_i) begin
      case (state_q)
        ACQ: begin
          lfsr_d = {lfsr_q[PRBS_ORDER-2:0], d_i};
          if (fill_q == FILL_FULL) begin
            // An all-zero window trivially predicts zero; refuse to lock on it.
            if (!mismatch_s && (lfsr_q != '0)) begin
              if (run_q == RUN_LAST) begin
                state_d = LOCKED;
                run_d   = '0;
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end else begin
              run_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        LOCKED: begin
          // Received bits are not fed back, so a single flip costs exactly one error.
          lfsr_d = {lfsr_q[PRBS_ORDER-2:0], pred_s};
          if (mismatch_s) begin
            cnt_inc_s   = 1'b1;
            err_pulse_d = 1'b1;
            if (cerr_q == CERR_LAST) begin
              state_d = ACQ;
              fill_d  = '0;
              run_d   = '0;
              cerr_d  = '0;
            end else begin
              cerr_d = cerr_q + CERR_W'(1);
            end
          end else begin
            cerr_d = '0;
          end
        end
        default: begin
          state_d = ACQ;
        end
      endcase
    end else begin
      err_pulse_d = 1'b0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      err_cnt_d = '0;
    end else if (cnt_inc_s && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACQ;
      lfsr_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      cerr_q      <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      cerr_q      <= cerr_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked_o    = (state_q == LOCKED);
  assign locked_d_o  = (state_d == LOCKED);
  assign err_cnt_o   = err_cnt_q;
  assign err_pulse_o = err_pulse_q;

endmodule

// File: rtl/zmod_prbs_checker.sv
// Receive-side PRBS-7 checker for the 4-lane ZMOD loopback link:
// independent per-lane lock/error checking plus a registered all-lanes-locked flag.
module zmod_prbs_checker
  import zmod_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_ERR = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [LANES-1:0]       d_in,
  input  logic                   clear,
  output logic [LANES-1:0]       locked,
  output logic                   all_locked,
  output logic [LANES*CNT_W-1:0] err_cnt,
  output logic [LANES-1:0]       err_pulse
);

  logic [LANES-1:0] locked_d_s;
  logic             all_locked_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    zmod_prbs_lane_check #(
      .CNT_W      (CNT_W),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_ERR (UNLOCK_ERR)
    ) u_lane (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .d_i         (d_in[i]),
      .clear_i     (clear),
      .locked_o    (locked[i]),
      .locked_d_o  (locked_d_s[i]),
      .err_cnt_o   (err_cnt[i*CNT_W +: CNT_W]),
      .err_pulse_o (err_pulse[i])
    );
  end

  // Built from next-state lock bits so it changes on the same edge as locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &locked_d_s;
    end
  end

  assign all_locked = all_locked_q;

endmodule
